perceptron_update: RTL and testbench
====================================

// Module: perceptron_update
// PURPOSE
// Learning-side counterpart of the step activation. Holds the perceptron weight vector.
// Takes the step output (y_pred) and target label (y_tgt) of one sample, then streams in
// that sample's N inputs and applies the perceptron rule w[i] += lr*(y_tgt-y_pred)*x[i].
// Sits beside the forward MAC/step path, which reads weights through the rd_* port.
// PARAMETERS
// PREC      16  data width of weights, inputs and labels (signed two's complement fixed point)
// FRAC       8  fractional bits of every PREC-wide value
// N          8  number of weights / inputs per sample (>=2)
// LR_SHIFT   4  learning rate = 2^-LR_SHIFT
// PORTS
// clk        in   1                  clock, all state on rising edge
// reset_     in   1                  asynchronous active-low reset
// wclr       in   1                  synchronous clear of all weights, honoured only in IDLE
// upd_valid  in   1                  update command valid
// upd_ready  out  1                  update command ready
// y_pred     in   PREC               step output for the sample
// y_tgt      in   PREC               target label for the sample
// x_valid    in   1                  input beat valid
// x_ready    out  1                  input beat ready
// x_data     in   PREC               input element x[idx]
// x_last     in   1                  marks final beat of the sample
// rd_addr    in   $clog2(N)          weight read index
// rd_data    out  PREC               w[rd_addr], combinational; 0 if rd_addr>=N
// busy       out  1                  state != IDLE
// done       out  1                  one-cycle pulse, update complete
// len_err    out  1                  sticky: x_last position != N-1
// BEHAVIOUR
// - Reset (async, reset_=0): state IDLE, all w=0, idx=0, err=0, done=0, len_err=0, busy=0.
//   Reset mid-stream aborts the update; partially written weights are zeroed, not kept.
// - FSM IDLE -> STREAM -> DONE -> IDLE.
//   IDLE:   upd_ready = !wclr; x_ready=0.
//           wclr=1 zeroes all w next edge and takes priority (no command accepted that cycle).
//           upd_valid&&upd_ready: err <= y_tgt - y_pred (PREC+1 bits signed), idx <= 0, ->STREAM.
//   STREAM: x_ready=1, upd_ready=0. Each accepted beat (x_valid&&x_ready) writes w[idx], idx++.
//           Beat with idx==N-1 -> DONE; len_err set if x_last=0 on that beat.
//           Beat with x_last=1 and idx<N-1 -> DONE, len_err<=1; remaining weights untouched.
//           No beat: idx and weights hold, no timeout.
//   DONE:   done=1 for exactly one cycle, -> IDLE. Next command accepted earliest the cycle after.
// - Arithmetic per beat:
//   - p = err * x_data, signed, 2*PREC+1 bits.
//   - d = p >>> (FRAC+LR_SHIFT), arithmetic shift, truncation toward -inf.
//   - w_new = w[idx] + d, computed wide.
//   - Saturate to [-2^(PREC-1), 2^(PREC-1)-1].
// - err==0: beats are still consumed and done pulses; weights stay bit-identical.
// - Latency: a weight written by the beat accepted at edge k appears on rd_data after edge k.
//   Command-to-done = N accepted beats + 1 cycle.
// - wclr outside IDLE is ignored. len_err is cleared only by reset.
// TESTING (PREC=16, FRAC=8, N=4, LR_SHIFT=0)
// - Basic update: y_tgt=0x0100, y_pred=0x0000; x=0x0100,0x0080,0xFF00,0x0000, x_last on beat 4
//   -> w=0x0100,0x0080,0xFF00,0x0000; done pulses 1 cycle after beat 4; len_err=0.
// - Saturation: preload w0=0x7F00 via updates, err=0x0200, x0=0x0100
//   -> w0=0x7FFF, not wrapped; negative mirror clamps to 0x8000.
// - Zero error: y_tgt=y_pred=0x0100, any x -> weights unchanged, done still pulses after 4 beats.
// - Early x_last on beat 2 -> len_err=1, DONE; w[2],w[3] unchanged; next command accepted normally.
// - Backpressure and clear: x_valid gaps of 3 cycles -> idx holds, same result as the basic update.
//   wclr together with upd_valid in IDLE -> weights 0, command not accepted that cycle.
// - Reset mid-stream after beat 2: reset_ low -> IDLE, all w=0, done=0, busy=0 immediately.

Source files
------------

// File: rtl/perceptron_update_if.sv
// Update-command and input-stream channel between a training controller and perceptron_update.
// The controller side is the master; the weight-update engine is the slave.
interface perceptron_update_if #(
    parameter int PREC = 16
);
    logic            upd_valid;
    logic            upd_ready;
    logic [PREC-1:0] y_pred;
    logic [PREC-1:0] y_tgt;
    logic            x_valid;
    logic            x_ready;
    logic [PREC-1:0] x_data;
    logic            x_last;

    modport master (
        output upd_valid, y_pred, y_tgt, x_valid, x_data, x_last,
        input  upd_ready, x_ready
    );

    modport slave (
        input  upd_valid, y_pred, y_tgt, x_valid, x_data, x_last,
        output upd_ready, x_ready
    );
endinterface

// File: rtl/perceptron_update.sv
// Perceptron weight store with the learning rule w[i] += lr*(y_tgt-y_pred)*x[i].
// One command latches the error, then N streamed inputs update the weights in order.
module perceptron_update #(
    parameter int PREC     = 16,
    parameter int FRAC     = 8,
    parameter int N        = 8,
    parameter int LR_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 reset_,
    input  logic                 wclr,
    perceptron_update_if.slave   bus,
    input  logic [$clog2(N)-1:0] rd_addr,
    output logic [PREC-1:0]      rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 len_err
);
    localparam int IDXW     = $clog2(N);
    localparam int SH       = FRAC + LR_SHIFT;
    localparam int PW       = 2 * PREC + 1;
    localparam int SW       = 2 * PREC + 2;
    localparam int RD_DEPTH = 1 << IDXW;

    localparam logic signed [SW-1:0] SAT_HI = {{(SW-PREC+1){1'b0}}, {(PREC-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_LO = {{(SW-PREC+1){1'b1}}, {(PREC-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [IDXW-1:0]      idx_reg;
    logic signed [PREC:0] err_reg;
    logic [PREC-1:0]      w_reg [N];
    logic                 len_err_reg;

    logic                 upd_ready, x_ready;
    logic                 cmd_fire, beat, last_idx, clr_fire;
    logic signed [PW-1:0] err_ext, x_ext, prod, delta;
    logic signed [SW-1:0] w_sum;
    logic [PREC-1:0]      w_cur, w_new;

    assign cmd_fire = bus.upd_valid && upd_ready;
    assign beat     = bus.x_valid && x_ready;
    assign last_idx = (idx_reg == IDXW'(N - 1));
    assign clr_fire = wclr && (state_reg == IDLE);

    always_comb begin
        state_next = state_reg;
        upd_ready  = 1'b0;
        x_ready    = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy      = 1'b0;
                upd_ready = !wclr;
                if (bus.upd_valid && !wclr)
                    state_next = STREAM;
            end
            STREAM: begin
                x_ready = 1'b1;
                if (bus.x_valid && (last_idx || bus.x_last))
                    state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.upd_ready = upd_ready;
    assign bus.x_ready   = x_ready;
    assign len_err       = len_err_reg;

    // Product is kept at full width so the floor shift sees every fractional bit.
    assign w_cur   = w_reg[idx_reg];
    assign err_ext = {{PREC{err_reg[PREC]}}, err_reg};
    assign x_ext   = {{(PREC+1){bus.x_data[PREC-1]}}, bus.x_data};
    assign prod    = err_ext * x_ext;
    assign delta   = prod >>> SH;
    assign w_sum   = {delta[PW-1], delta} + {{(PREC+2){w_cur[PREC-1]}}, w_cur};

    always_comb begin
        w_new = w_sum[PREC-1:0];
        if (w_sum > SAT_HI)
            w_new = SAT_HI[PREC-1:0];
        else if (w_sum < SAT_LO)
            w_new = SAT_LO[PREC-1:0];
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            err_reg     <= '0;
            len_err_reg <= 1'b0;
            for (int i = 0; i < N; i++)
                w_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (cmd_fire) begin
                err_reg <= {bus.y_tgt[PREC-1], bus.y_tgt} - {bus.y_pred[PREC-1], bus.y_pred};
                idx_reg <= '0;
            end
            if (beat) begin
                idx_reg        <= idx_reg + IDXW'(1);
                w_reg[idx_reg] <= w_new;
                // Flags both a missing x_last on the final slot and an early x_last.
                if (bus.x_last != last_idx)
                    len_err_reg <= 1'b1;
            end
            if (clr_fire) begin
                for (int i = 0; i < N; i++)
                    w_reg[i] <= '0;
            end
        end
    end

    // Read table padded to a power of two so out-of-range addresses return zero.
    logic [PREC-1:0] rd_tab [RD_DEPTH];

    generate
        for (genvar gi = 0; gi < RD_DEPTH; gi++) begin : g_rd
            if (gi < N) begin : g_w
                assign rd_tab[gi] = w_reg[gi];
            end else begin : g_z
                assign rd_tab[gi] = '0;
            end
        end
    endgenerate

    assign rd_data = rd_tab[rd_addr];
endmodule

// File: tb/tb_perceptron_update.sv
// Randomized scoreboard bench for perceptron_update (PREC=16, FRAC=8, N=4, LR_SHIFT=0).
// A floor-division reference model predicts weights; a monitor checks each done pulse.
module tb_perceptron_update;
    localparam int PREC = 16;
    localparam int FRAC = 8;
    localparam int N    = 4;
    localparam int LRS  = 0;
    localparam int SH   = FRAC + LRS;

    typedef struct {
        logic [N-1:0][PREC-1:0] w;
        bit                     le;
        int                     cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_;
    logic            wclr;
    logic [1:0]      rd_addr, stim_addr, mon_addr;
    logic            mon_owns;
    logic [PREC-1:0] rd_data;
    logic            busy, done, len_err;

    perceptron_update_if #(.PREC(PREC)) bus ();

    perceptron_update #(.PREC(PREC), .FRAC(FRAC), .N(N), .LR_SHIFT(LRS)) dut (
        .clk     (clk),
        .reset_  (reset_),
        .wclr    (wclr),
        .bus     (bus.slave),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd_addr = mon_owns ? mon_addr : stim_addr;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    logic [PREC-1:0] wm [N];
    bit              lerr_m;
    logic [PREC-1:0] stim_x [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    function automatic logic [PREC-1:0] model_upd(input logic [PREC-1:0] w, input int e,
                                                 input logic [PREC-1:0] x);
        longint p, s;
        real    dr;
        p  = longint'(e) * longint'($signed(x));
        dr = $floor(real'(p) / real'(longint'(1) << SH));
        s  = longint'($signed(w)) + longint'(dr);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s[PREC-1:0];
    endfunction

    task automatic rd_chk(input string name, input int a, input logic [PREC-1:0] expv);
        stim_addr = a[1:0];
        #1;
        chk(name, rd_data, expv);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) wm[i] = '0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        wclr = 1'b1;
        @(posedge clk);
        #1;
        wclr = 1'b0;
        model_clear();
    endtask

    // Issue one command then nb beats; x_last on beat nb unless no_last.
    task automatic send_sample(input logic [PREC-1:0] tgt, input logic [PREC-1:0] pred,
                               input int nb, input int gap, input bit clr_mid, input bit no_last);
        int   e;
        exp_t ex;
        e = int'($signed(tgt)) - int'($signed(pred));
        @(negedge clk);
        bus.upd_valid = 1'b1;
        bus.y_tgt     = tgt;
        bus.y_pred    = pred;
        for (int t = 0; t < 20 && !bus.upd_ready; t++) @(negedge clk);
        chk("upd_ready", bus.upd_ready, 1);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        for (int b = 0; b < nb; b++) begin
            repeat (gap) @(negedge clk);
            @(negedge clk);
            bus.x_valid = 1'b1;
            bus.x_data  = stim_x[b];
            bus.x_last  = !no_last && (b == nb - 1);
            wclr        = clr_mid;
            for (int t = 0; t < 20 && !bus.x_ready; t++) @(negedge clk);
            chk("x_ready", bus.x_ready, 1);
            @(posedge clk);
            #1;
            bus.x_valid = 1'b0;
            bus.x_last  = 1'b0;
            wclr        = 1'b0;
            wm[b] = model_upd(wm[b], e, stim_x[b]);
            if (!no_last && b == nb - 1) begin
                if (b != N - 1) lerr_m = 1'b1;
                for (int i = 0; i < N; i++) ex.w[i] = wm[i];
                ex.le  = lerr_m;
                ex.cyc = cyc;
                sb_q.push_back(ex);
            end
        end
        if (!no_last) begin
            for (int t = 0; t < 10 && busy; t++) @(negedge clk);
            chk("idle_after_done", busy, 0);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected update.
    initial begin
        exp_t ex;
        mon_owns = 1'b0;
        mon_addr = '0;
        forever begin
            @(negedge clk);
            if (reset_ !== 1'b1) begin
                // nothing to match while held in reset
            end else if (done) begin
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    ex = sb_q.pop_front();
                    chk("done_cycle", cyc, ex.cyc);
                    chk("done_len_err", len_err, ex.le);
                    chk("done_busy", busy, 1);
                    mon_owns = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        mon_addr = i[1:0];
                        #1;
                        chk($sformatf("done_w%0d", i), rd_data, ex.w[i]);
                    end
                    mon_owns = 1'b0;
                    $display("update done @%0d: w=%h %h %h %h len_err=%0d",
                             cyc, ex.w[0], ex.w[1], ex.w[2], ex.w[3], ex.le);
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
                chk("done_missing", 0, 1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        reset_        = 1'b1;
        wclr          = 1'b0;
        stim_addr     = '0;
        bus.upd_valid = 1'b0;
        bus.y_tgt     = '0;
        bus.y_pred    = '0;
        bus.x_valid   = 1'b0;
        bus.x_data    = '0;
        bus.x_last    = 1'b0;
        lerr_m        = 1'b0;
        model_clear();
        #1 reset_ = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_upd_ready", bus.upd_ready, 1);
        chk("rst_x_ready", bus.x_ready, 0);
        for (int i = 0; i < N; i++) rd_chk($sformatf("rst_w%0d", i), i, 16'h0000);
        @(negedge clk);
        reset_ = 1'b1;

        // Basic update, then the same sample with 3-cycle gaps between beats
        stim_x[0] = 16'h0100; stim_x[1] = 16'h0080; stim_x[2] = 16'hFF00; stim_x[3] = 16'h0000;
        send_sample(16'h0100, 16'h0000, 4, 0, 1'b0, 1'b0);
        rd_chk("basic_w0", 0, 16'h0100);
        rd_chk("basic_w1", 1, 16'h0080);
        rd_chk("basic_w2", 2, 16'hFF00);
        rd_chk("basic_w3", 3, 16'h0000);
        do_clear();
        send_sample(16'h0100, 16'h0000, 4, 3, 1'b0, 1'b0);
        rd_chk("gap_w1", 1, 16'h0080);
        rd_chk("gap_w2", 2, 16'hFF00);

        // Positive and negative saturation of w0
        stim_x[0] = 16'h0100; stim_x[1] = 16'h0000; stim_x[2] = 16'h0000; stim_x[3] = 16'h0000;
        do_clear();
        send_sample(16'h7F00, 16'h0000, 4, 0, 1'b0, 1'b0);
        send_sample(16'h0200, 16'h0000, 4, 0, 1'b0, 1'b0);
        rd_chk("sat_hi_w0", 0, 16'h7FFF);
        do_clear();
        send_sample(16'h8100, 16'h0000, 4, 0, 1'b0, 1'b0);
        send_sample(16'hFE00, 16'h0000, 4, 0, 1'b0, 1'b0);
        rd_chk("sat_lo_w0", 0, 16'h8000);

        // Zero error leaves weights untouched
        for (int i = 0; i < N; i++) stim_x[i] = PREC'($urandom);
        send_sample(16'h0100, 16'h0100, 4, 1, 1'b0, 1'b0);
        rd_chk("zero_err_w0", 0, 16'h8000);

        // wclr with a pending command: clear wins, command not taken
        @(negedge clk);
        wclr          = 1'b1;
        bus.upd_valid = 1'b1;
        #1;
        chk("clr_upd_ready", bus.upd_ready, 0);
        @(posedge clk);
        #1;
        wclr          = 1'b0;
        bus.upd_valid = 1'b0;
        model_clear();
        chk("clr_not_accepted", busy, 0);
        for (int i = 0; i < N; i++) rd_chk($sformatf("clr_w%0d", i), i, 16'h0000);

        // Early x_last on beat 2, then a normal command
        for (int i = 0; i < N; i++) stim_x[i] = PREC'($urandom);
        send_sample(PREC'($urandom), PREC'($urandom), 2, 0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) stim_x[i] = PREC'($urandom);
        send_sample(PREC'($urandom), PREC'($urandom), 4, 0, 1'b1, 1'b0);

        // Reset in the middle of a stream, after beat 2
        send_sample(16'h0300, 16'h0000, 2, 0, 1'b0, 1'b1);
        #2;
        reset_ = 1'b0;
        #1;
        model_clear();
        lerr_m = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_len_err", len_err, 0);
        for (int i = 0; i < N; i++) rd_chk($sformatf("midrst_w%0d", i), i, 16'h0000);
        @(negedge clk);
        reset_ = 1'b1;

        // Randomized updates with gaps and ignored mid-stream clears
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < N; i++) stim_x[i] = PREC'($urandom);
            send_sample(PREC'($urandom), PREC'($urandom), 4, int'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
